// File: rtl/sprite_anim_sequencer_pkg.sv
// Shared definitions for the sprite animation sequencer: playback types and
// the ping-pong direction state.
package sprite_anim_sequencer_pkg;

  localparam logic [1:0] ANIM_LOOP     = 2'd0;
  localparam logic [1:0] ANIM_PINGPONG = 2'd1;
  localparam logic [1:0] ANIM_ONESHOT  = 2'd2;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/anim_tick_divider.sv
// Free-running period divider: tick marks the last cycle of each TICK_DIV-cycle
// period; hold freezes the count, clr restarts the period from zero.
module anim_tick_divider #(
  parameter int TICK_DIV = 2**21
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  if (TICK_DIV < 2) begin : g_bad_div
    $error("anim_tick_divider: TICK_DIV must be at least 2");
  end

  assign tick = (div_cnt == CNT_MAX) && !hold;

  // clr wins over hold so a restart always begins a full period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else if (!hold) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sprite_anim_sequencer.sv
// Sprite animation frame sequencer: per-mode frame ranges with loop, ping-pong
// or one-shot playback, pause/restart, a frame tick pulse and a one-shot done flag.
module sprite_anim_sequencer
  import sprite_anim_sequencer_pkg::*;
#(
  parameter int FRAME_W   = 3,
  parameter int NUM_MODES = 4,
  parameter int TICK_DIV  = 2**21,
  parameter logic [NUM_MODES*FRAME_W-1:0] MODE_BASE = {3'd7, 3'd6, 3'd3, 3'd0},
  parameter logic [NUM_MODES*FRAME_W-1:0] MODE_LEN  = {3'd1, 3'd1, 3'd3, 3'd3},
  parameter logic [NUM_MODES*2-1:0]       MODE_TYPE = {2'd0, 2'd0, 2'd0, 2'd0},
  localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MODE_W-1:0]  mode_sel,
  input  logic               pause,
  input  logic               restart,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_tick,
  output logic               done
);

  for (genvar m = 0; m < NUM_MODES; m++) begin : g_chk
    if ((MODE_LEN[m*FRAME_W +: FRAME_W] == 0) ||
        (int'(MODE_BASE[m*FRAME_W +: FRAME_W]) + int'(MODE_LEN[m*FRAME_W +: FRAME_W])
         > 2**FRAME_W)) begin : g_bad_mode
      $error("sprite_anim_sequencer: mode %0d frame range is illegal", m);
    end
  end

  logic [MODE_W-1:0]  mode_q;
  logic [MODE_W-1:0]  mode_eff;
  logic [MODE_W-1:0]  mode_n;
  logic [FRAME_W-1:0] offset;
  logic [FRAME_W-1:0] offset_n;
  dir_e               dir;
  dir_e               dir_n;
  logic               done_n;
  logic               start;
  logic               tick_raw;
  logic               adv;
  logic [FRAME_W-1:0] len_m1;
  logic [1:0]         type_cur;
  logic [FRAME_W-1:0] base_n;

  // Out-of-range mode requests fall back to mode 0
  assign mode_eff = (32'(mode_sel) < NUM_MODES) ? mode_sel : '0;
  assign start    = (mode_eff != mode_q) || restart;
  assign adv      = tick_raw && !start;
  assign mode_n   = start ? mode_eff : mode_q;
  assign len_m1   = MODE_LEN[32'(mode_q)*FRAME_W +: FRAME_W] - 1'b1;
  assign type_cur = MODE_TYPE[32'(mode_q)*2 +: 2];
  assign base_n   = MODE_BASE[32'(mode_n)*FRAME_W +: FRAME_W];

  anim_tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .hold(pause),
    .tick(tick_raw)
  );

  always_comb begin
    offset_n = offset;
    dir_n    = dir;
    done_n   = done;
    if (start) begin
      offset_n = '0;
      dir_n    = DIR_UP;
      done_n   = 1'b0;
    end else if (adv) begin
      case (type_cur)
        ANIM_PINGPONG: begin
          // a single-frame range has no turning points, so it simply holds
          if (len_m1 != '0) begin
            if (dir == DIR_UP) begin
              offset_n = offset + 1'b1;
              if (offset_n == len_m1) dir_n = DIR_DOWN;
            end else begin
              offset_n = offset - 1'b1;
              if (offset_n == '0) dir_n = DIR_UP;
            end
          end
        end
        ANIM_ONESHOT: begin
          if (offset != len_m1) offset_n = offset + 1'b1;
          if (offset_n == len_m1) done_n = 1'b1;
        end
        default: begin
          offset_n = (offset == len_m1) ? '0 : offset + 1'b1;
        end
      endcase
    end
  end

  // frame is built from the next-state values so it updates on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= '0;
      offset     <= '0;
      dir        <= DIR_UP;
      done       <= 1'b0;
      frame      <= MODE_BASE[FRAME_W-1:0];
      frame_tick <= 1'b0;
    end else begin
      mode_q     <= mode_n;
      offset     <= offset_n;
      dir        <= dir_n;
      done       <= done_n;
      frame      <= base_n + offset_n;
      frame_tick <= adv;
    end
  end

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Self-checking bench: four sequencer configurations share one stimulus stream
// and are compared every cycle against a step-count based playback model.
module tb_sprite_anim_sequencer;

  localparam int TD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      mode_sel = 2'd0;
  logic            pause = 1'b0;
  logic            restart = 1'b0;
  logic [3:0][2:0] frame_v;
  logic [3:0]      tick_v;
  logic [3:0]      done_v;

  int total = 0;
  int bad   = 0;

  int m_mode[4];
  int m_p[4];
  int m_phase[4];
  int m_tick[4];

  always #5 clk = ~clk;

  sprite_anim_sequencer #(.TICK_DIV(TD)) u0 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .pause(pause), .restart(restart),
    .frame(frame_v[0]), .frame_tick(tick_v[0]), .done(done_v[0])
  );

  sprite_anim_sequencer #(.TICK_DIV(TD), .MODE_TYPE({2'd0, 2'd0, 2'd1, 2'd0})) u1 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .pause(pause), .restart(restart),
    .frame(frame_v[1]), .frame_tick(tick_v[1]), .done(done_v[1])
  );

  sprite_anim_sequencer #(.TICK_DIV(TD), .MODE_TYPE({2'd0, 2'd0, 2'd2, 2'd0})) u2 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .pause(pause), .restart(restart),
    .frame(frame_v[2]), .frame_tick(tick_v[2]), .done(done_v[2])
  );

  sprite_anim_sequencer #(
    .TICK_DIV(TD), .NUM_MODES(3),
    .MODE_BASE({3'd6, 3'd3, 3'd0}), .MODE_LEN({3'd1, 3'd3, 3'd3}), .MODE_TYPE(6'd0)
  ) u3 (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .pause(pause), .restart(restart),
    .frame(frame_v[3]), .frame_tick(tick_v[3]), .done(done_v[3])
  );

  function automatic int cfg_nm(int i);
    return (i == 3) ? 3 : 4;
  endfunction

  function automatic int cfg_base(int m);
    case (m)
      0: return 0;
      1: return 3;
      2: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic int cfg_len(int m);
    return (m < 2) ? 3 : 1;
  endfunction

  function automatic int cfg_type(int i, int m);
    if (i == 1 && m == 1) return 1;
    if (i == 2 && m == 1) return 2;
    return 0;
  endfunction

  // Offset as a pure function of how many ticks have elapsed since the start
  function automatic int exp_frame(int i);
    int L, p, t, off, per;
    L = cfg_len(m_mode[i]);
    p = m_p[i];
    t = cfg_type(i, m_mode[i]);
    if (t == 1) begin
      if (L == 1) off = 0;
      else begin
        per = 2 * (L - 1);
        off = (p % per < L) ? p % per : per - p % per;
      end
    end else if (t == 2) begin
      off = (p < L - 1) ? p : L - 1;
    end else begin
      off = p % L;
    end
    return (cfg_base(m_mode[i]) + off) % 8;
  endfunction

  function automatic int exp_done(int i);
    return (cfg_type(i, m_mode[i]) == 2 && m_p[i] >= 1 && m_p[i] >= cfg_len(m_mode[i]) - 1) ? 1 : 0;
  endfunction

  task automatic checkOutput(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge rst) begin
    int eff;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_mode[i] = 0; m_p[i] = 0; m_phase[i] = 0; m_tick[i] = 0;
      end else begin
        eff = (int'(mode_sel) < cfg_nm(i)) ? int'(mode_sel) : 0;
        if (eff != m_mode[i] || restart) begin
          m_mode[i] = eff; m_p[i] = 0; m_phase[i] = 0; m_tick[i] = 0;
        end else if (pause) begin
          m_tick[i] = 0;
        end else if (m_phase[i] == TD - 1) begin
          m_phase[i] = 0; m_p[i]++; m_tick[i] = 1;
        end else begin
          m_phase[i]++; m_tick[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("u%0d_frame", i), int'(frame_v[i]), exp_frame(i));
      checkOutput($sformatf("u%0d_tick", i), int'(tick_v[i]), m_tick[i]);
      checkOutput($sformatf("u%0d_done", i), int'(done_v[i]), exp_done(i));
    end
  end

  task automatic applyStimulus(int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if ($urandom_range(15) == 0) mode_sel = 2'($urandom_range(3));
      restart = ($urandom_range(39) == 0);
      if ($urandom_range(9) == 0) pause = ~pause;
      rst = ($urandom_range(499) == 0);
    end
  endtask

  initial begin
    step(2);
    checkOutput("rst_frame", int'(frame_v[0]), 0);
    checkOutput("rst_tick", int'(tick_v[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    step(4);
    checkOutput("loop_f1", int'(frame_v[0]), 1);
    checkOutput("loop_t1", int'(tick_v[0]), 1);
    step(4);
    checkOutput("loop_f2", int'(frame_v[0]), 2);
    step(4);
    checkOutput("loop_wrap", int'(frame_v[0]), 0);
    step(3);
    mode_sel = 2'd1;
    step(1);
    checkOutput("sw_frame", int'(frame_v[0]), 3);
    checkOutput("sw_notick", int'(tick_v[0]), 0);
    step(3);
    checkOutput("sw_hold", int'(frame_v[0]), 3);
    step(1);
    checkOutput("sw_next", int'(frame_v[0]), 4);
    checkOutput("pp_4", int'(frame_v[1]), 4);
    step(4);
    checkOutput("pp_5", int'(frame_v[1]), 5);
    checkOutput("os_5", int'(frame_v[2]), 5);
    checkOutput("os_done", int'(done_v[2]), 1);
    step(4);
    checkOutput("pp_back4", int'(frame_v[1]), 4);
    checkOutput("os_hold", int'(frame_v[2]), 5);
    step(4);
    checkOutput("pp_back3", int'(frame_v[1]), 3);
    step(4);
    checkOutput("pp_up4", int'(frame_v[1]), 4);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    checkOutput("rs_frame", int'(frame_v[2]), 3);
    checkOutput("rs_done", int'(done_v[2]), 0);
    step(2);
    pause = 1'b1;
    step(10);
    checkOutput("pz_frame", int'(frame_v[0]), 3);
    pause = 1'b0;
    step(1);
    checkOutput("pz_resume1", int'(frame_v[0]), 3);
    step(1);
    checkOutput("pz_resume2", int'(frame_v[0]), 4);
    mode_sel = 2'd2;
    step(1);
    checkOutput("m2_frame", int'(frame_v[0]), 6);
    step(4);
    checkOutput("m2_tick", int'(tick_v[0]), 1);
    checkOutput("m2_static", int'(frame_v[0]), 6);
    mode_sel = 2'd3;
    step(1);
    checkOutput("m3_frame", int'(frame_v[0]), 7);
    checkOutput("nm3_alias", int'(frame_v[3]), 0);
    step(4);
    checkOutput("nm3_adv", int'(frame_v[3]), 1);
    mode_sel = 2'd1;
    step(16);
    checkOutput("pre_rst_done", int'(done_v[2]), 1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("arst_frame", int'(frame_v[0]), 0);
    checkOutput("arst_tick", int'(tick_v[0]), 0);
    checkOutput("arst_done", int'(done_v[2]), 0);
    #3;
    rst = 1'b0;
    applyStimulus(3000);
    rst = 1'b0;
    step(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
